// File: rtl/bist_mem_responder.sv
// Memory-side responder for the BIST March controller: address counter, memory
// under test, data comparator, failure log and optional stuck-at fault on bit 0.
module bist_mem_responder #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reset,
  input  logic              preset,
  input  logic              en,
  input  logic              up_down,
  input  logic              read,
  input  logic              write,
  input  logic              out,
  input  logic              log_clr,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic              inj_val,
  output logic              carry,
  output logic              is_equal,
  output logic [ADDR_W-1:0] addr,
  output logic              fail_seen,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [ERR_W-1:0]  err_count
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] MAX     = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX = '1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pattern;
  logic [DATA_W-1:0] rdata;
  logic              at_term;
  logic              log_event;

  assign pattern   = {DATA_W{out}};
  assign at_term   = up_down ? (addr == MAX) : (addr == '0);
  assign carry     = en & at_term;
  assign is_equal  = (rdata == pattern);
  assign log_event = en & read & ~write & ~is_equal;

  // The fault sits on the read path only so the stored word stays intact.
  always_comb begin
    rdata = mem[addr];
    if (inj_en && (addr == inj_addr)) begin
      rdata[0] = inj_val;
    end
  end

  // Counter holds at terminal count instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (reset) begin
      addr <= '0;
    end else if (preset) begin
      addr <= MAX;
    end else if (en && !at_term) begin
      addr <= up_down ? addr + 1'b1 : addr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (en && write) begin
      mem[addr] <= pattern;
    end
  end

  // The log survives reset/preset so results outlive the controller's return to RST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_seen       <= 1'b0;
      first_fail_addr <= '0;
      err_count       <= '0;
    end else if (log_clr) begin
      fail_seen       <= 1'b0;
      first_fail_addr <= '0;
      err_count       <= '0;
    end else if (log_event) begin
      if (err_count != ERR_MAX) begin
        err_count <= err_count + 1'b1;
      end
      if (!fail_seen) begin
        fail_seen       <= 1'b1;
        first_fail_addr <= addr;
      end
    end
  end

endmodule

// File: tb/tb_bist_mem_responder.sv
// Table-driven bench for bist_mem_responder with a scoreboard queue of expected values.
module tb_bist_mem_responder;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int ERR_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              reset, preset, en, up_down, read, write, out, log_clr, inj_en, inj_val;
  logic [ADDR_W-1:0] inj_addr;
  logic              carry, is_equal, fail_seen;
  logic [ADDR_W-1:0] addr, first_fail_addr;
  logic [ERR_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit rs, pr, en, ud, rd, wr, o, clr, inj;
    int a, c, q, f, fa, e;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  bist_mem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .reset(reset), .preset(preset), .en(en),
    .up_down(up_down), .read(read), .write(write), .out(out), .log_clr(log_clr),
    .inj_en(inj_en), .inj_addr(inj_addr), .inj_val(inj_val),
    .carry(carry), .is_equal(is_equal), .addr(addr), .fail_seen(fail_seen),
    .first_fail_addr(first_fail_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic add(input bit rs, pr, en_i, ud, rd, wr, o, clr, inj,
                     input int a, c, q, f, fa, e);
    vec_t v;
    v.rs = rs; v.pr = pr; v.en = en_i; v.ud = ud; v.rd = rd; v.wr = wr;
    v.o = o; v.clr = clr; v.inj = inj;
    v.a = a; v.c = c; v.q = q; v.f = f; v.fa = fa; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic compare_top(input string tag);
    vec_t x;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
      return;
    end
    x = sb.pop_front();
    check({tag, " addr"},     int'(addr), x.a);
    check({tag, " carry"},    int'(carry), x.c);
    check({tag, " is_equal"}, int'(is_equal), x.q);
    check({tag, " fail_seen"}, int'(fail_seen), x.f);
    check({tag, " first_fail_addr"}, int'(first_fail_addr), x.fa);
    check({tag, " err_count"}, int'(err_count), x.e);
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    reset = v.rs; preset = v.pr; en = v.en; up_down = v.ud; read = v.rd;
    write = v.wr; out = v.o; log_clr = v.clr; inj_en = v.inj;
    sb.push_back(v);
    @(negedge clk);
    compare_top($sformatf("step%0d", idx));
  endtask

  function automatic int min3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  initial begin
    int split;
    vec_t rv;
    rst_n = 1'b0;
    reset = 0; preset = 0; en = 0; up_down = 0; read = 0; write = 0;
    out = 0; log_clr = 0; inj_en = 0; inj_addr = 2'd2; inj_val = 1'b0;

    // Dirty the memory with out=1 before the mid-run reset.
    add(0,0,1,1,0,1,1,0,0, 0,0,0,0,0,0);
    add(0,0,1,1,0,1,1,0,0, 1,0,0,0,0,0);
    split = tbl.size();
    // W0 up: holds at MAX
    for (int i = 0; i < 5; i++)
      add(0,0,1,1,0,1,0,0,0, (i > 3) ? 3 : i, (i >= 3) ? 1 : 0, 1,0,0,0);
    // R0 down: holds at 0
    for (int i = 0; i < 5; i++)
      add(0,0,1,0,1,0,0,0,0, (i > 3) ? 0 : 3 - i, (i >= 3) ? 1 : 0, 1,0,0,0);
    add(0,0,0,0,0,0,0,0,0, 0,0,1,0,0,0);
    // Fault at word 2: write ones, then read up
    add(1,0,0,0,0,0,0,0,1, 0,0,1,0,0,0);
    for (int i = 0; i < 4; i++)
      add(0,0,1,1,0,1,1,0,1, i, (i == 3) ? 1 : 0, 0,0,0,0);
    add(1,0,0,0,0,0,1,0,1, 3,0,1,0,0,0);
    add(0,0,1,1,1,0,1,0,1, 0,0,1,0,0,0);
    add(0,0,1,1,1,0,1,0,1, 1,0,1,0,0,0);
    add(0,0,1,1,1,0,1,0,1, 2,0,0,0,0,0);
    add(0,0,1,1,1,0,1,0,1, 3,1,1,1,2,1);
    add(0,0,0,0,0,0,1,0,1, 3,0,1,1,2,1);
    // reset beats preset; preset alone loads MAX; log untouched
    add(1,1,0,0,0,0,1,0,1, 3,0,1,1,2,1);
    add(0,1,0,0,0,0,1,0,1, 0,0,1,1,2,1);
    add(0,0,0,0,0,0,1,0,1, 3,0,1,1,2,1);
    // Repeated read passes: counter saturates, first address sticks
    for (int p = 0; p < 4; p++) begin
      add(1,0,0,0,0,0,1,0,1, 3,0,1,1,2,min3(1 + p));
      add(0,0,1,1,1,0,1,0,1, 0,0,1,1,2,min3(1 + p));
      add(0,0,1,1,1,0,1,0,1, 1,0,1,1,2,min3(1 + p));
      add(0,0,1,1,1,0,1,0,1, 2,0,0,1,2,min3(1 + p));
      add(0,0,1,1,1,0,1,0,1, 3,1,1,1,2,min3(2 + p));
    end
    // log_clr wins over a same-cycle mismatch at word 2
    add(0,0,1,0,1,0,1,0,1, 3,0,1,1,2,3);
    add(0,0,1,0,1,0,1,1,1, 2,0,0,1,2,3);
    // read+write together: write happens, no log
    add(0,0,1,0,1,1,0,0,1, 1,0,0,0,0,0);
    add(0,0,1,1,0,0,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,0,1, 1,0,1,0,0,0);
    // read without en is ignored, then a logged read at word 1
    add(0,0,0,1,1,0,1,0,1, 1,0,0,0,0,0);
    add(0,0,1,1,1,0,1,0,1, 1,0,0,0,0,0);
    add(0,0,0,0,0,0,1,0,0, 2,0,1,1,1,1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < split; i++) apply(tbl[i], i);

    // Asynchronous reset mid-run: clears counter, memory and log at once.
    @(posedge clk);
    #1;
    reset = 0; preset = 0; en = 0; up_down = 0; read = 0; write = 0;
    out = 0; log_clr = 0; inj_en = 0;
    rst_n = 1'b0;
    rv = '{rs:0, pr:0, en:0, ud:0, rd:0, wr:0, o:0, clr:0, inj:0,
           a:0, c:0, q:1, f:0, fa:0, e:0};
    sb.push_back(rv);
    #2;
    compare_top("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = split; i < tbl.size(); i++) apply(tbl[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
